// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage with IF/ID register. One outstanding imem request,
// a one-entry skid buffer for words that return while decode is stalled.
module fetch_stage #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_pc_plus4
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
  } fetch_t;

  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] pc, pc_n;
  fetch_t                skid, skid_n, ld;
  logic                  load;

  assign imem_req  = (state == S_REQ);
  assign imem_addr = pc;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    skid_n  = skid;
    load    = 1'b0;
    ld      = skid;
    case (state)
      S_REQ:  if (imem_gnt) state_n = S_WAIT;
      S_WAIT: if (imem_rvalid) begin
        pc_n = pc + FOUR;
        if (stall) begin
          skid_n  = '{instr: imem_rdata, pc: pc};
          state_n = S_HOLD;
        end else begin
          load    = 1'b1;
          ld      = '{instr: imem_rdata, pc: pc};
          state_n = S_REQ;
        end
      end
      S_HOLD: if (!stall) begin
        load    = 1'b1;
        state_n = S_REQ;
      end
      S_DROP: if (imem_rvalid) state_n = S_REQ;
      default: state_n = S_REQ;
    endcase
    // Redirect wins: drop any word in hand, track whether a response is still in flight.
    if (redirect) begin
      load = 1'b0;
      pc_n = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      case (state)
        S_REQ:   state_n = imem_gnt    ? S_DROP : S_REQ;
        S_WAIT:  state_n = imem_rvalid ? S_REQ  : S_DROP;
        S_HOLD:  state_n = S_REQ;
        default: state_n = imem_rvalid ? S_REQ  : S_DROP;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      skid  <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      skid  <= skid_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
    end else if (redirect) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (load) begin
      id_valid    <= 1'b1;
      id_instr    <= ld.instr;
      id_pc       <= ld.pc;
      id_pc_plus4 <= ld.pc + FOUR;
    end else if (!stall) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random stall/redirect/memory timing,
// checked against an architectural model (expected PC stream, address-derived words).
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  int          total = 0, bad = 0;
  int          gnt_pct = 100, lat_min = 0, lat_max = 0;
  int          ndel = 0, gap = 0;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0;
  logic [31:0] exp_pc = '0;
  logic        got;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: memory answers, then the model checks the new outputs at negedge.
  task automatic tick();
    logic        p_req, p_gnt, p_rv, p_stall, p_redir;
    logic [31:0] p_addr, p_rpc, p_ipc, p_ipc4, p_instr;
    logic        p_val;
    imem_gnt    = imem_req && ($urandom_range(99) < gnt_pct);
    imem_rvalid = pend && (pend_cnt == 0);
    imem_rdata  = pend ? memw(pend_addr) : 32'hDEAD_BEEF;
    p_req = imem_req; p_gnt = imem_gnt; p_rv = imem_rvalid; p_addr = imem_addr;
    p_stall = stall; p_redir = redirect; p_rpc = redirect_pc;
    p_val = id_valid; p_instr = id_instr; p_ipc = id_pc; p_ipc4 = id_pc_plus4;
    @(posedge clk);
    @(negedge clk);
    if (p_rv) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (p_req && p_gnt) begin
      pend = 1'b1; pend_addr = p_addr; pend_cnt = $urandom_range(lat_max, lat_min);
    end
    got = 1'b0;
    chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    if (pend) chk("one_outstanding", {31'd0, imem_req}, 32'd0);
    if (p_req && !p_gnt && !p_redir) begin
      chk("req_hold", {31'd0, imem_req}, 32'd1);
      chk("addr_hold", imem_addr, p_addr);
    end
    if (p_redir) begin
      exp_pc = {p_rpc[31:2], 2'b00};
      gap = 0;
      chk("redir_valid", {31'd0, id_valid}, 32'd0);
      chk("redir_nop", id_instr, NOP);
      chk("redir_pc_hold", id_pc, p_ipc);
      if (!pend) begin
        chk("redir_req", {31'd0, imem_req}, 32'd1);
        chk("redir_addr", imem_addr, exp_pc);
      end
    end else if (p_stall) begin
      chk("stall_valid", {31'd0, id_valid}, {31'd0, p_val});
      chk("stall_instr", id_instr, p_instr);
      chk("stall_pc", id_pc, p_ipc);
      chk("stall_pc4", id_pc_plus4, p_ipc4);
    end else if (id_valid) begin
      got = 1'b1; ndel++; gap = 0;
      chk("deliv_pc", id_pc, exp_pc);
      chk("deliv_instr", id_instr, memw(exp_pc));
      chk("deliv_pc4", id_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end else begin
      chk("bubble_nop", id_instr, NOP);
      chk("bubble_pc", id_pc, p_ipc);
      chk("bubble_pc4", id_pc_plus4, p_ipc4);
    end
    if (!got) gap++;
    if (gap > 300) begin
      chk("liveness", 32'd0, 32'd1);
      gap = 0;
    end
  endtask

  task automatic wait_deliv(input string tag);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (got) return;
    end
    chk(tag, 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd0);
    rst = 1'b0;

    // back-to-back fetch: one instruction every two cycles
    repeat (6) tick();
    chk("seq_count", ndel, 32'd3);
    chk("seq_next_addr", imem_addr, 32'd12);

    // stall across the returning word -> skid buffer, no fetch while held
    stall = 1'b1;
    repeat (2) tick();
    chk("hold_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    chk("hold_noreq2", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    chk("hold_rel_pc", id_pc, 32'd12);
    chk("hold_rel_valid", {31'd0, id_valid}, 32'd1);
    chk("hold_next_addr", imem_addr, 32'd16);

    // redirect while waiting for a slow response
    lat_min = 1; lat_max = 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("drop_noreq", {31'd0, imem_req}, 32'd0);
    redirect = 1'b0;
    wait_deliv("drop_timeout");
    chk("drop_target", id_pc, 32'h40);

    // redirect and stall together while a word sits in the skid buffer
    lat_min = 0; lat_max = 0; stall = 1'b1;
    repeat (2) tick();
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0; stall = 1'b0;
    wait_deliv("hold_redir_timeout");
    chk("hold_redir_target", id_pc, 32'h80);

    // grant withheld, then redirect without a DROP
    gnt_pct = 0;
    repeat (4) tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("nognt_addr", imem_addr, 32'h100);
    chk("nognt_req", {31'd0, imem_req}, 32'd1);
    redirect = 1'b0; gnt_pct = 100;
    wait_deliv("nognt_timeout");
    chk("nognt_target", id_pc, 32'h100);

    // PC wrap and unaligned redirect target
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    wait_deliv("wrap_timeout");
    chk("wrap_pc4", id_pc_plus4, 32'd0);
    chk("wrap_addr", imem_addr, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    chk("unalign_addr", imem_addr, 32'h100);
    redirect = 1'b0;

    // random memory timing, stalls and redirects
    gnt_pct = 60; lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom_range(99) < 30);
      redirect = ($urandom_range(99) < 4);
      redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                             : $urandom;
      tick();
    end
    stall = 1'b0; redirect = 1'b0;
    wait_deliv("final_timeout");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
